cordic_result_buf: RTL
======================

CORDIC_RESULT_BUF -- requirements
Module: cordic_result_buf

Interface
REQ-001 Parameter LATENCY, 17, cycles from an accepted issue to the matching result on mul_y/mul_z; equals multiplier input-register-to-output depth.
REQ-002 Parameter DEPTH, 32, result FIFO entries, power of two, DEPTH >= LATENCY.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream presents an operand set to the multiplier this cycle.
REQ-006 in_ready  output  1  buffer guarantees space for the result; issue accepted when in_valid && in_ready.
REQ-007 mul_y  input  16  multiplier Y result.
REQ-008 mul_z  input  16  multiplier Z residual.
REQ-009 out_valid  output  1  FIFO head valid.
REQ-010 out_ready  input  1  consumer accepts head.
REQ-011 out_y  output  16  head Y value.
REQ-012 out_z  output  16  head Z value (see REQ-030).
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 Valid delay line: LATENCY-deep 1-bit shift register, input = in_valid && in_ready; tap asserts push in the cycle mul_y/mul_z carry the matching result.
REQ-015 On push, {mul_y, mul_z} written at write pointer; pointer wraps modulo DEPTH.
REQ-016 Pop = out_valid && out_ready; read pointer advances, wraps modulo DEPTH.
REQ-017 First-word latency: push on edge N -> out_valid high from cycle N+1; head read combinationally from storage.
REQ-018 out_y/out_z = 0 whenever out_valid = 0.
REQ-019 inflight counter (0..LATENCY): +1 on accept, -1 on push, unchanged when both occur in the same cycle.
REQ-020 in_ready = !rst && (count + inflight < DEPTH); a pop in the current cycle does not raise in_ready until the next cycle.
REQ-021 Push and pop in the same cycle: count unchanged, both pointers advance; legal when full only if push is guaranteed not to exceed DEPTH (ensured by REQ-020).
REQ-022 No push occurs unless a credit was taken; FIFO never overflows; pop on empty impossible (out_valid = 0).
REQ-023 Ordering: results emerge in issue order; no reordering or drops.
REQ-024 Sustained throughput: one accept and one pop per cycle when out_ready held high.
REQ-025 Multiplier is not stalled; backpressure acts solely via in_ready.

Reset
REQ-026 While rst high: delay line, pointers, count, inflight cleared; out_valid = 0, in_ready = 0, out_y = out_z = 0.
REQ-027 First cycle after rst low: in_ready = 1, count = 0.
REQ-028 Reset mid-operation: results already in the multiplier are discarded (their valid bits cleared); none produce a push after reset.
REQ-029 Storage array contents are not reset.

Configuration
REQ-030 Macro CORDIC_RESBUF_ZOUT_EN: defined -> FIFO 32 bits wide, out_z carries the stored mul_z; undefined -> FIFO 16 bits wide, mul_z ignored, out_z tied to 0.

Verification
REQ-031 Reset: rst high 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, count = 0; after release in_ready = 1.
REQ-032 Single issue at cycle 0, model drives mul_y = 0x1234, mul_z = 0x0003 at cycle 17 -> out_valid = 1 at cycle 18, out_y = 0x1234, out_z = 0x0003 (macro on) / 0 (off); pop -> count = 0.
REQ-033 out_ready = 0, in_valid = 1 continuously -> exactly 32 accepts, in_ready = 0 from cycle 32; count = 32 at cycle 49; contents 32 distinct values in order.
REQ-034 Steady state in_valid = out_ready = 1 -> one pop per cycle after fill, count constant, in_ready stays 1.
REQ-035 10 issues in flight, rst pulse 1 cycle -> no out_valid for 20 following cycles with in_valid = 0.
REQ-036 Full FIFO, single pop -> in_ready rises next cycle; accept plus concurrent pop keeps count + inflight = 32.

Source files
------------

// File: rtl/cordic_result_buf.sv
// Result FIFO behind a fixed-latency multiplier: issues take a credit against free space and a valid delay line marks results.
// Build option CORDIC_RESBUF_ZOUT_EN stores mul_z next to mul_y; without it out_z is tied to zero.
module cordic_result_buf #(
  parameter int LATENCY = 17,
  parameter int DEPTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              mul_y,
  input  logic [15:0]              mul_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_y,
  output logic [15:0]              out_z,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int IW = $clog2(LATENCY + 1);
`ifdef CORDIC_RESBUF_ZOUT_EN
  localparam int W = 32;
`else
  localparam int W = 16;
`endif

  logic [LATENCY-1:0] vld_sr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [IW-1:0]      inflight;
  logic [W-1:0]       mem [DEPTH];
  logic [W-1:0]       wr_data;
  logic [W-1:0]       head;
  logic [SW-1:0]      credit_sum;
  logic               accept;
  logic               push;
  logic               pop;

  assign accept     = in_valid && in_ready;
  assign push       = vld_sr[LATENCY-1];
  assign pop        = out_valid && out_ready;
  // Results still inside the multiplier already own a FIFO slot.
  assign credit_sum = SW'(count) + SW'(inflight);
  assign in_ready   = !rst && (credit_sum < SW'(DEPTH));
  assign out_valid  = !rst && (count != '0);
  assign head       = mem[rd_ptr];
  assign out_y      = out_valid ? head[W-1 -: 16] : 16'h0;

`ifdef CORDIC_RESBUF_ZOUT_EN
  assign wr_data = {mul_y, mul_z};
  assign out_z   = out_valid ? head[15:0] : 16'h0;
`else
  logic unused_mul_z;
  assign unused_mul_z = ^mul_z;
  assign wr_data      = mul_y;
  assign out_z        = 16'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | LATENCY'(accept);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({accept, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately left unreset; head is masked by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end

endmodule
